// File: rtl/rob_v2.sv
// Reorder buffer: in-order allocate, out-of-order writeback,
// in-order multi-slot retire with flush.
module rob_v2 #(
   parameter int DEPTH    = 64,
   parameter int DATA_W   = 32,
   parameter int PREG_W   = 6,
   parameter int PC_W     = 12,
   parameter int WB_PORTS = 3,
   parameter int RET_W    = 2,
   localparam int IDX_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         alloc_valid,
   input  logic [PREG_W-1:0]            alloc_rd,
   input  logic [PREG_W-1:0]            alloc_rd_old,
   input  logic [PC_W-1:0]              alloc_pc,
   output logic                         alloc_ready,
   output logic [IDX_W-1:0]             alloc_tag,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0]    wb_tag,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
   output logic [RET_W-1:0]             ret_valid,
   output logic [RET_W*PREG_W-1:0]      ret_rd,
   output logic [RET_W*PREG_W-1:0]      ret_rd_old,
   output logic [RET_W*DATA_W-1:0]      ret_data,
   output logic [RET_W*PC_W-1:0]        ret_pc,
   output logic [CNT_W-1:0]             count,
   output logic                         empty,
   output logic                         full
);

   logic [DEPTH-1:0]  val_q, val_d, cmp_q, cmp_d;
   logic [PREG_W-1:0] rd_q [DEPTH];
   logic [PREG_W-1:0] rd_d [DEPTH];
   logic [PREG_W-1:0] rdo_q [DEPTH];
   logic [PREG_W-1:0] rdo_d [DEPTH];
   logic [PC_W-1:0]   pc_q [DEPTH];
   logic [PC_W-1:0]   pc_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              empty_q, empty_d, full_q, full_d;

   logic [RET_W-1:0]        rv_q, rv_d;
   logic [RET_W*PREG_W-1:0] rrd_q, rrd_d, rrdo_q, rrdo_d;
   logic [RET_W*DATA_W-1:0] rdat_q, rdat_d;
   logic [RET_W*PC_W-1:0]   rpc_q, rpc_d;

   logic [RET_W-1:0] rmask;
   logic [CNT_W-1:0] rn;
   logic             acc;

   assign acc = alloc_valid && !full_q && !flush;

   // Retire scan sees only pre-edge complete bits
   always_comb begin
      logic             stop;
      logic [IDX_W-1:0] ridx;
      rmask = '0;
      rn    = '0;
      stop  = 1'b0;
      ridx  = '0;
      for (int k = 0; k < RET_W; k++) begin
         ridx = head_q + IDX_W'(k);
         if (!stop && val_q[ridx] && cmp_q[ridx]) begin
            rmask[k] = 1'b1;
            rn       = rn + CNT_W'(1);
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_comb begin
      logic [IDX_W-1:0] t;
      val_d   = val_q;
      cmp_d   = cmp_q;
      rd_d    = rd_q;
      rdo_d   = rdo_q;
      pc_d    = pc_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      empty_d = empty_q;
      full_d  = full_q;
      rv_d    = '0;
      rrd_d   = '0;
      rrdo_d  = '0;
      rdat_d  = '0;
      rpc_d   = '0;
      t       = '0;
      if (flush) begin
         val_d   = '0;
         cmp_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         cnt_d   = '0;
         empty_d = 1'b1;
         full_d  = 1'b0;
      end else begin
         // Ascending port order lets the highest port win a tag clash
         for (int p = 0; p < WB_PORTS; p++) begin
            t = wb_tag[p*IDX_W +: IDX_W];
            if (wb_valid[p] && val_q[t]) begin
               cmp_d[t]  = 1'b1;
               data_d[t] = wb_data[p*DATA_W +: DATA_W];
            end
         end
         for (int k = 0; k < RET_W; k++) begin
            t = head_q + IDX_W'(k);
            if (rmask[k]) begin
               val_d[t] = 1'b0;
               cmp_d[t] = 1'b0;
               rrd_d[k*PREG_W +: PREG_W]  = rd_q[t];
               rrdo_d[k*PREG_W +: PREG_W] = rdo_q[t];
               rdat_d[k*DATA_W +: DATA_W] = data_q[t];
               rpc_d[k*PC_W +: PC_W]      = pc_q[t];
            end
         end
         rv_d = rmask;
         if (acc) begin
            val_d[tail_q]  = 1'b1;
            cmp_d[tail_q]  = 1'b0;
            rd_d[tail_q]   = alloc_rd;
            rdo_d[tail_q]  = alloc_rd_old;
            pc_d[tail_q]   = alloc_pc;
            data_d[tail_q] = '0;
            tail_d         = tail_q + IDX_W'(1);
         end
         head_d  = head_q + IDX_W'(rn);
         cnt_d   = cnt_q + CNT_W'(acc) - rn;
         empty_d = (cnt_d == '0);
         full_d  = (cnt_d == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q   <= '0;
         cmp_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         rv_q    <= '0;
         rrd_q   <= '0;
         rrdo_q  <= '0;
         rdat_q  <= '0;
         rpc_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            rdo_q[i]  <= '0;
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         val_q   <= val_d;
         cmp_q   <= cmp_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         rv_q    <= rv_d;
         rrd_q   <= rrd_d;
         rrdo_q  <= rrdo_d;
         rdat_q  <= rdat_d;
         rpc_q   <= rpc_d;
         rd_q    <= rd_d;
         rdo_q   <= rdo_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
      end
   end

   assign alloc_ready = !full_q;
   assign alloc_tag   = tail_q;
   assign ret_valid   = rv_q;
   assign ret_rd      = rrd_q;
   assign ret_rd_old  = rrdo_q;
   assign ret_data    = rdat_q;
   assign ret_pc      = rpc_q;
   assign count       = cnt_q;
   assign empty       = empty_q;
   assign full        = full_q;

endmodule

// File: tb/tb_rob_v2.sv
// Scoreboard bench for rob_v2 (DEPTH=4, RET_W=2, WB_PORTS=3):
// directed scenarios followed by a random phase.
module tb_rob_v2;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int PREG_W = 6;
   localparam int PC_W   = 12;
   localparam int WBP    = 3;
   localparam int RET_W  = 2;
   localparam int IDX_W  = 2;
   localparam int CNT_W  = 3;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic                      flush = 1'b0;
   logic                      alloc_valid = 1'b0;
   logic [PREG_W-1:0]         alloc_rd = '0;
   logic [PREG_W-1:0]         alloc_rd_old = '0;
   logic [PC_W-1:0]           alloc_pc = '0;
   logic                      alloc_ready;
   logic [IDX_W-1:0]          alloc_tag;
   logic [WBP-1:0]            wb_valid = '0;
   logic [WBP*IDX_W-1:0]      wb_tag = '0;
   logic [WBP*DATA_W-1:0]     wb_data = '0;
   logic [RET_W-1:0]          ret_valid;
   logic [RET_W*PREG_W-1:0]   ret_rd, ret_rd_old;
   logic [RET_W*DATA_W-1:0]   ret_data;
   logic [RET_W*PC_W-1:0]     ret_pc;
   logic [CNT_W-1:0]          count;
   logic                      empty, full;

   rob_v2 #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W),
      .PC_W(PC_W), .WB_PORTS(WBP), .RET_W(RET_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_rd_old(alloc_rd_old), .alloc_pc(alloc_pc),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .ret_valid(ret_valid), .ret_rd(ret_rd),
      .ret_rd_old(ret_rd_old), .ret_data(ret_data),
      .ret_pc(ret_pc), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDX_W-1:0]  tag;
      logic [PREG_W-1:0] rd;
      logic [PREG_W-1:0] rdo;
      logic [PC_W-1:0]   pc;
      logic              cmp;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t sb[$];
   ent_t rexp[$];
   int   mtail;
   int   n_cmp;
   int   n_bad;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      rexp.delete();
      mtail = 0;
   endtask

   task automatic check_outputs();
      int n;
      n = rexp.size();
      check_eq("ret_valid", 64'(ret_valid), 64'((1 << n) - 1));
      for (int k = 0; k < RET_W; k++) begin
         if (k < n) begin
            check_eq($sformatf("ret_pc%0d", k),
                     64'(ret_pc[k*PC_W +: PC_W]), 64'(rexp[k].pc));
            check_eq($sformatf("ret_rd%0d", k),
                     64'(ret_rd[k*PREG_W +: PREG_W]), 64'(rexp[k].rd));
            check_eq($sformatf("ret_rdo%0d", k),
                     64'(ret_rd_old[k*PREG_W +: PREG_W]), 64'(rexp[k].rdo));
            check_eq($sformatf("ret_data%0d", k),
                     64'(ret_data[k*DATA_W +: DATA_W]), 64'(rexp[k].data));
         end else begin
            check_eq($sformatf("ret_data%0d_idle", k),
                     64'(ret_data[k*DATA_W +: DATA_W]), 64'd0);
            check_eq($sformatf("ret_pc%0d_idle", k),
                     64'(ret_pc[k*PC_W +: PC_W]), 64'd0);
         end
      end
      check_eq("count", 64'(count), 64'(sb.size()));
      check_eq("empty", 64'(empty), 64'(sb.size() == 0));
      check_eq("full", 64'(full), 64'(sb.size() == DEPTH));
      check_eq("alloc_tag", 64'(alloc_tag), 64'(mtail));
      check_eq("alloc_ready", 64'(alloc_ready), 64'(sb.size() != DEPTH));
   endtask

   // Model step from the inputs currently driven, then clock and compare
   task automatic tick();
      bit   full_pre;
      int   n;
      ent_t e;
      full_pre = (sb.size() == DEPTH);
      rexp.delete();
      if (flush) begin
         sb.delete();
         mtail = 0;
      end else begin
         n = 0;
         while (n < RET_W && n < sb.size() && sb[n].cmp) n++;
         for (int k = 0; k < n; k++) rexp.push_back(sb.pop_front());
         for (int p = 0; p < WBP; p++) begin
            if (wb_valid[p]) begin
               foreach (sb[i]) begin
                  if (sb[i].tag == wb_tag[p*IDX_W +: IDX_W]) begin
                     sb[i].cmp  = 1'b1;
                     sb[i].data = wb_data[p*DATA_W +: DATA_W];
                  end
               end
            end
         end
         if (alloc_valid && !full_pre) begin
            e.tag  = IDX_W'(mtail);
            e.rd   = alloc_rd;
            e.rdo  = alloc_rd_old;
            e.pc   = alloc_pc;
            e.cmp  = 1'b0;
            e.data = '0;
            sb.push_back(e);
            mtail = (mtail + 1) % DEPTH;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      wb_valid    = '0;
   endtask

   task automatic set_alloc(int pc, int rd, int rdo);
      alloc_valid  = 1'b1;
      alloc_pc     = PC_W'(pc);
      alloc_rd     = PREG_W'(rd);
      alloc_rd_old = PREG_W'(rdo);
   endtask

   task automatic set_wb(int p, int tag, logic [DATA_W-1:0] d);
      wb_valid[p]                 = 1'b1;
      wb_tag[p*IDX_W +: IDX_W]    = IDX_W'(tag);
      wb_data[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic alloc1(int pc, int rd, int rdo);
      set_alloc(pc, rd, rdo);
      tick();
      idle();
   endtask

   initial begin
      logic [PC_W-1:0] pc3;
      n_cmp = 0;
      n_bad = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_outputs();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Out-of-order writeback, two-wide retire
      for (int i = 0; i < 3; i++) alloc1(12'h100 + 4 * i, i + 1, i + 33);
      set_wb(0, 1, 32'h11);
      tick();
      idle();
      check_eq("no_retire_tag1", 64'(ret_valid), 64'd0);
      set_wb(1, 0, 32'h10);
      tick();
      idle();
      check_eq("wb_retire_latency", 64'(ret_valid), 64'd0);
      tick();
      check_eq("pair_retire", 64'(ret_valid), 64'b11);
      check_eq("pair_data", 64'(ret_data), 64'h00000011_00000010);
      check_eq("pair_count", 64'(count), 64'd1);

      // Flush with three live entries and concurrent alloc/wb
      alloc1(12'h200, 4, 36);
      alloc1(12'h204, 5, 37);
      flush = 1'b1;
      set_alloc(12'h208, 6, 38);
      set_wb(0, 3, 32'hDEAD);
      tick();
      idle();
      check_eq("flush_count", 64'(count), 64'd0);
      check_eq("flush_empty", 64'(empty), 64'd1);
      check_eq("flush_tag", 64'(alloc_tag), 64'd0);

      // Fill, drop while full, free a slot, wrap allocation
      for (int i = 0; i < 4; i++) alloc1(12'h300 + 4 * i, 8 + i, 40 + i);
      check_eq("full_flag", 64'(full), 64'd1);
      check_eq("full_ready", 64'(alloc_ready), 64'd0);
      set_alloc(12'h555, 20, 50);
      tick();
      check_eq("drop_count", 64'(count), 64'd4);
      set_wb(2, 0, 32'h30);
      tick();
      wb_valid = '0;
      tick();
      check_eq("free_count", 64'(count), 64'd3);
      tick();
      idle();
      check_eq("wrap_tag", 64'(alloc_tag), 64'd1);
      check_eq("wrap_count", 64'(count), 64'd4);

      // Same-tag writeback clash, then wrap-around retire
      set_wb(0, 3, 32'hA);
      set_wb(2, 3, 32'hB);
      tick();
      idle();
      set_wb(0, 1, 32'h31);
      set_wb(1, 2, 32'h32);
      set_wb(2, 0, 32'h40);
      tick();
      idle();
      tick();
      pc3 = 12'h30C;
      tick();
      check_eq("wrap_retire", 64'(ret_valid), 64'b11);
      check_eq("clash_data", 64'(ret_data[31:0]), 64'hB);
      check_eq("wrap_pc0", 64'(ret_pc[11:0]), 64'(pc3));
      check_eq("wrap_pc1", 64'(ret_pc[23:12]), 64'h555);
      check_eq("wrap_empty", 64'(empty), 64'd1);

      // Asynchronous reset between clock edges
      alloc1(12'h600, 1, 2);
      alloc1(12'h604, 3, 4);
      set_wb(0, 1, 32'h77);
      tick();
      idle();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      alloc1(12'h700, 9, 10);
      check_eq("post_reset_tag", 64'(alloc_tag), 64'd1);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(99) < 60)
            set_alloc($urandom_range(4095), $urandom_range(63),
                      $urandom_range(63));
         for (int p = 0; p < WBP; p++)
            if ($urandom_range(99) < 30)
               set_wb(p, $urandom_range(DEPTH - 1), $urandom);
         if ($urandom_range(99) < 3) flush = 1'b1;
         tick();
         idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rob_v2.md
ROB_V2 -- requirements
Module: rob_v2

Interface
REQ-001 Parameter DEPTH, default 64: ROB entries; power of two, >= 4.
REQ-002 Parameter DATA_W, default 32: result width.
REQ-003 Parameter PREG_W, default 6: physical register tag width.
REQ-004 Parameter PC_W, default 12: PC width.
REQ-005 Parameter WB_PORTS, default 3: writeback ports.
REQ-006 Parameter RET_W, default 2: max retires per cycle, 1..DEPTH.
REQ-007 IDX_W = clog2(DEPTH); CNT_W = clog2(DEPTH)+1 (derived, not overridable).
REQ-008 clk  in  1  single clock; all state updates on its rising edge only.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 flush  in  1  discard all in-flight entries.
REQ-011 alloc_valid  in  1  request to allocate one entry.
REQ-012 alloc_rd / alloc_rd_old  in  PREG_W each  new and previous physical dest.
REQ-013 alloc_pc  in  PC_W  instruction PC.
REQ-014 alloc_ready  out  1  combinational, = !full.
REQ-015 alloc_tag  out  IDX_W  combinational, index the next accepted allocation receives (= tail).
REQ-016 wb_valid  in  WB_PORTS  per-port writeback strobe.
REQ-017 wb_tag  in  WB_PORTS*IDX_W  packed entry indices, port p at [p*IDX_W +: IDX_W].
REQ-018 wb_data  in  WB_PORTS*DATA_W  packed results.
REQ-019 ret_valid  out  RET_W  registered; slot k valid, slots filled from 0 contiguously.
REQ-020 ret_rd, ret_rd_old  out  RET_W*PREG_W each; ret_data  out  RET_W*DATA_W; ret_pc  out  RET_W*PC_W; all registered, packed per slot.
REQ-021 count  out  CNT_W; empty, full  out  1; all registered.

Function
REQ-022 Entry holds valid, complete, rd, rd_old, pc, data; head and tail are IDX_W-bit pointers wrapping modulo DEPTH.
REQ-023 Allocation accepted iff alloc_valid && !full && !flush; entry[tail] <= {valid=1, complete=0, fields, data=0}; tail <= tail+1.
REQ-024 Allocation while full is dropped, no state change; source must hold until alloc_ready.
REQ-025 Each wb port p with wb_valid[p] and entry[wb_tag[p]].valid sets complete=1 and data=wb_data[p]; wb to an invalid entry is ignored.
REQ-026 Two ports writing the same tag in one cycle: highest-numbered port's data wins.
REQ-027 Retire: n = number of consecutive entries from head, n <= min(RET_W, count), each valid && complete; scan stops at first non-complete entry.
REQ-028 Retiring entries: valid cleared, fields copied to ret slots 0..n-1 in program order, ret_valid = (1<<n)-1, head <= head+n; unused slots valid=0, data fields 0.
REQ-029 Retire decision uses pre-edge complete bits: a writeback is retirable no earlier than the edge after it is captured (min 1-cycle wb-to-retire latency).
REQ-030 count <= count + accepted_alloc - n; empty <= (next count == 0); full <= (next count == DEPTH).
REQ-031 Full and retire same cycle: alloc still dropped (full is registered); slot frees next cycle.
REQ-032 Retire past index DEPTH-1 wraps to 0 within one cycle (e.g. head=DEPTH-1, n=2 -> head=1).
REQ-033 flush has priority over alloc, wb and retire: all valid/complete cleared, head=tail=0, count=0, empty=1, full=0, ret_valid=0 at that edge.

Reset
REQ-034 rst_n low asynchronously forces: head=tail=0, all valid/complete=0, count=0, empty=1, full=0, ret_valid=0, all ret data 0; hence alloc_tag=0, alloc_ready=1.
REQ-035 Reset mid-operation discards all entries; first allocation after release gets tag 0.
REQ-036 No initial blocks; reset is the only initialisation.

Verification (DEPTH=4, RET_W=2, WB_PORTS=3)
REQ-037 Reset, alloc 3 (tags 0,1,2), wb tag1 data 0x11 -> no retire; wb tag0 0x10 -> next edge ret_valid=2'b11, ret_data {0x11,0x10}, count=1.
REQ-038 Alloc 4 -> full=1, alloc_ready=0; 5th alloc dropped; retire tag0 -> count=3 next edge, then alloc accepted with tag 0 (wrap).
REQ-039 Same-cycle wb on ports 0 and 2 to tag 3 with 0xA, 0xB -> retired data 0xB.
REQ-040 Entries at head=3 and 0 complete -> both retire one cycle, head=1, ret_pc in program order.
REQ-041 flush with 3 valid entries plus concurrent alloc/wb -> count=0, empty=1, ret_valid=0, next alloc_tag=0.
REQ-042 rst_n low mid-stream between edges -> outputs at reset values immediately, before the next clk edge.
